// File: rtl/masked_bv8_inv_rand_sched_if.sv
// Bundle between the randomness scheduler, the PRNG, the operand source and
// the stage1/stage2/stage3 inverse datapath.
//
// Handshakes: a PRNG word moves when in_rand_valid && out_rand_ready at a
// rising edge; an operand moves (out_issue) when in_valid && out_ready.
// Both ready signals depend only on registered state, never on the matching
// valid, so a producer may hold valid high and wait without a loop.
//
// dbg_state / dbg_cnt expose the sequencer state and buffer fill level for
// checkers.
interface masked_bv8_inv_rand_sched_if #(
  parameter int RAND_WIDTH = 32,
  parameter int S1_BITS    = 8,
  parameter int S2_BITS    = 16,
  parameter int S3_BITS    = 8
);
  localparam int CNT_W = $clog2(S1_BITS + S2_BITS + S3_BITS + RAND_WIDTH + 1);

  logic [RAND_WIDTH-1:0] in_rand_word;
  logic                  in_rand_valid;
  logic                  out_rand_ready;
  logic                  in_valid;
  logic                  out_ready;
  logic                  out_issue;
  logic [S1_BITS-1:0]    out_random_s1;
  logic [S2_BITS-1:0]    out_random_s2;
  logic [S3_BITS-1:0]    out_random_s3;
  logic                  out_valid;
  logic                  in_drain;
  logic                  out_idle;
  logic                  dbg_state;
  logic [CNT_W-1:0]      dbg_cnt;

  // Scheduler side
  modport slave (
    input  in_rand_word, in_rand_valid, in_valid, in_drain,
    output out_rand_ready, out_ready, out_issue, out_random_s1,
           out_random_s2, out_random_s3, out_valid, out_idle,
           dbg_state, dbg_cnt
  );

  // Environment side (operand source, PRNG, datapath)
  modport master (
    output in_rand_word, in_rand_valid, in_valid, in_drain,
    input  out_rand_ready, out_ready, out_issue, out_random_s1,
           out_random_s2, out_random_s3, out_valid, out_idle,
           dbg_state, dbg_cnt
  );
endinterface

// File: rtl/masked_bv8_inv_rand_sched.sv
// Randomness scheduler for the three-stage masked GF(2^8) inverse (HPC1).
// Buffers PRNG words, admits an operand only when a full set of stage
// randomness is buffered, hands each stage its slice in the cycle that stage
// captures the token, and tracks tokens in flight for valid/idle.
//
// Optional feature: define MASKED_INV_SCHED_STATS_EN to add out_starve_count,
// a saturating count of cycles an operand waited on randomness.
module masked_bv8_inv_rand_sched #(
  parameter int NUM_SHARES = 2,
  parameter int RAND_WIDTH = 32,
  parameter int S1_BITS    = 4 * NUM_SHARES * (NUM_SHARES - 1),
  parameter int S2_BITS    = 8 * NUM_SHARES * (NUM_SHARES - 1),
  parameter int S3_BITS    = 4 * NUM_SHARES * (NUM_SHARES - 1)
) (
  input  logic                       in_clock,
  input  logic                       in_reset,
  masked_bv8_inv_rand_sched_if.slave bus
`ifdef MASKED_INV_SCHED_STATS_EN
  ,
  output logic [15:0]                out_starve_count
`endif
);
  localparam int TOTAL_BITS = S1_BITS + S2_BITS + S3_BITS;
  localparam int BUF_BITS   = TOTAL_BITS + RAND_WIDTH;
  localparam int CNT_W      = $clog2(BUF_BITS + 1);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL_BITS);
  localparam logic [CNT_W-1:0] RAND_C  = CNT_W'(RAND_WIDTH);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [BUF_BITS-1:0] bit_buf_q, bit_buf_nxt, shifted, ins_mask, ins_word;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt, base;
  logic [0:0]          state_q, state_nxt;
  logic [2:0]          v_q;
  logic [S2_BITS-1:0]  s2_q;
  logic [S3_BITS-1:0]  s3_a_q, s3_b_q;
  logic                rand_ready, ready, accept, issue;

  // Readies come from registered state only.
  assign rand_ready = (cnt_q <= TOTAL_C);
  assign ready      = (state_q == ST_RUN) && (cnt_q >= TOTAL_C);
  assign accept     = bus.in_rand_valid && rand_ready;
  assign issue      = bus.in_valid && ready;

  // Buffer update: drop the consumed set on issue, then append a new word
  // just above the surviving valid bits.
  always_comb begin
    shifted  = issue ? (bit_buf_q >> TOTAL_BITS) : bit_buf_q;
    base     = issue ? (cnt_q - TOTAL_C) : cnt_q;
    ins_mask = {{(BUF_BITS-RAND_WIDTH){1'b0}}, {RAND_WIDTH{1'b1}}} << base;
    ins_word = {{(BUF_BITS-RAND_WIDTH){1'b0}}, bus.in_rand_word} << base;
    bit_buf_nxt = shifted;
    cnt_nxt     = base;
    if (accept) begin
      bit_buf_nxt = (shifted & ~ins_mask) | ins_word;
      cnt_nxt     = base + RAND_C;
    end
  end

  // Buffer and fill-count registers.
  always_ff @(posedge in_clock) begin
    if (!in_reset) begin
      bit_buf_q <= '0;
      cnt_q     <= '0;
    end else begin
      bit_buf_q <= bit_buf_nxt;
      cnt_q     <= cnt_nxt;
    end
  end

  // Admission FSM: leave RUN on drain request, return once drained and released.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_RUN:   if (bus.in_drain) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!bus.in_drain && (v_q == 3'b000)) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge in_clock) begin
    if (!in_reset) state_q <= ST_RUN;
    else           state_q <= state_nxt;
  end

  // Token valid pipe, one bit per stage.
  always_ff @(posedge in_clock) begin
    if (!in_reset) v_q <= 3'b000;
    else           v_q <= {v_q[1:0], issue};
  end

  // Later-stage slices ride along with their token; they only move on the
  // issue-shifted enables so every slice reaches exactly one token.
  always_ff @(posedge in_clock) begin
    if (!in_reset) begin
      s2_q   <= '0;
      s3_a_q <= '0;
      s3_b_q <= '0;
    end else begin
      if (issue) begin
        s2_q   <= bit_buf_q[S1_BITS +: S2_BITS];
        s3_a_q <= bit_buf_q[S1_BITS+S2_BITS +: S3_BITS];
      end
      if (v_q[0]) s3_b_q <= s3_a_q;
    end
  end

`ifdef MASKED_INV_SCHED_STATS_EN
  logic [15:0] starve_q;

  // Saturating count of cycles an operand waited for randomness while running.
  always_ff @(posedge in_clock) begin
    if (!in_reset) starve_q <= 16'h0000;
    else if (bus.in_valid && (state_q == ST_RUN) && (cnt_q < TOTAL_C) &&
             (starve_q != 16'hFFFF))
      starve_q <= starve_q + 16'h0001;
  end

  assign out_starve_count = starve_q;
`endif

  assign bus.out_rand_ready = rand_ready;
  assign bus.out_ready      = ready;
  assign bus.out_issue      = issue;
  assign bus.out_random_s1  = bit_buf_q[S1_BITS-1:0];
  assign bus.out_random_s2  = s2_q;
  assign bus.out_random_s3  = s3_b_q;
  assign bus.out_valid      = v_q[2];
  assign bus.out_idle       = (v_q == 3'b000);
  assign bus.dbg_state      = state_q;
  assign bus.dbg_cnt        = cnt_q;
endmodule
